// File: rtl/gray_seq_ctrl.sv
// Sequencer for a gray_Nbits LED counter: paced clk_en generation, clear, run-length,
// pause/single-step, and a binary reference model that cross-checks the counter's gray_out.
//   state | meaning
//   IDLE  | waiting for start, no enables
//   CLR   | one cycle holding the counter in reset
//   RUN   | prescaler paces enables to the counter
//   PAUSE | enables halted, prescaler held
//   STEP  | one-cycle single enable issued from PAUSE
//   DONE  | run length reached, waiting for start
module gray_seq_ctrl #(
  parameter int N  = 4,
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          step,
  input  logic [PW-1:0] period,
  input  logic [CW-1:0] cycles,
  input  logic [N-1:0]  gray_in,
  output logic          gray_clk_en,
  output logic          gray_rst,
  output logic          busy,
  output logic          done,
  output logic          step_ack,
  output logic          err,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, PAUSE, STEP, DONE} state_t;

  state_t        state;
  logic [PW-1:0] period_q;
  logic [PW-1:0] presc;
  logic [CW-1:0] cycles_q;
  logic [N-1:0]  en_cnt;

  logic          wrap;
  logic          finish;
  logic          presc_hit;
  logic          checked;
  logic [CW-1:0] cnt_inc;
  logic [N-1:0]  model_gray;

  assign cnt_inc    = cycle_cnt + 1'b1;
  assign wrap       = gray_clk_en && (en_cnt == '1);
  // The enable that wraps the model is the one that may close the run.
  assign finish     = wrap && (cycles_q != '0) && (cnt_inc == cycles_q);
  assign presc_hit  = (presc == period_q);
  assign model_gray = en_cnt ^ (en_cnt >> 1);
  assign checked    = (state == RUN) || (state == PAUSE) || (state == STEP) || (state == DONE);

  assign gray_rst = rst | (state == CLR);
  assign busy     = (state == CLR) || (state == RUN) || (state == PAUSE) || (state == STEP);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gray_clk_en <= 1'b0;
      step_ack    <= 1'b0;
      err         <= 1'b0;
      cycle_cnt   <= '0;
      en_cnt      <= '0;
      presc       <= '0;
      period_q    <= '0;
      cycles_q    <= '0;
    end else begin
      gray_clk_en <= 1'b0;
      step_ack    <= 1'b0;

      if (gray_clk_en)
        en_cnt <= en_cnt + 1'b1;
      if (wrap && (cycle_cnt != '1))
        cycle_cnt <= cnt_inc;
      if (checked && (gray_in != model_gray))
        err <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= CLR;
            period_q  <= period;
            cycles_q  <= cycles;
            cycle_cnt <= '0;
            en_cnt    <= '0;
            presc     <= '0;
            err       <= 1'b0;
          end
        end
        CLR: state <= RUN;
        RUN: begin
          // Leaving RUN suppresses the next enable and freezes the prescaler.
          if (finish)
            state <= DONE;
          else if (stop)
            state <= PAUSE;
          else if (presc_hit) begin
            presc       <= '0;
            gray_clk_en <= 1'b1;
          end else
            presc <= presc + 1'b1;
        end
        PAUSE: begin
          if (!stop) begin
            if (step) begin
              state       <= STEP;
              gray_clk_en <= 1'b1;
              step_ack    <= 1'b1;
            end else if (start)
              state <= RUN;
          end
        end
        STEP: state <= finish ? DONE : PAUSE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: expected enables (cycle, gray_in, step_ack) are
// queued by the stimulus and popped by a monitor on every gray_clk_en pulse.
module tb_gray_seq_ctrl;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop, step;
  logic [PW-1:0] period;
  logic [CW-1:0] cycles;
  logic [N-1:0]  gray_in;
  logic          gray_clk_en, gray_rst, busy, done, step_ack, err;
  logic [CW-1:0] cycle_cnt;

  gray_seq_ctrl #(.N(N), .PW(PW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .period(period), .cycles(cycles), .gray_in(gray_in),
    .gray_clk_en(gray_clk_en), .gray_rst(gray_rst), .busy(busy), .done(done),
    .step_ack(step_ack), .err(err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for gray_Nbits, with an optional stuck-at-zero output fault
  logic [N-1:0] gcnt;
  logic         stuck;
  always @(posedge clk)
    if (gray_rst) gcnt <= '0;
    else if (gray_clk_en) gcnt <= gcnt + 1'b1;
  assign gray_in = stuck ? '0 : (gcnt ^ (gcnt >> 1));

  typedef struct {
    int         at;
    logic       ack;
    logic [3:0] g;
  } exp_t;
  exp_t sb[$];

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_en(input int at, input logic ack, input logic [3:0] g);
    exp_t e;
    e.at = at; e.ack = ack; e.g = g;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (gray_clk_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_enable: enable at cycle %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        check("en_cycle", cyc, e.at);
        check("en_gray_in", {28'd0, gray_in}, {28'd0, e.g});
        check("en_step_ack", {31'd0, step_ack}, {31'd0, e.ack});
      end
    end else if (step_ack === 1'b1) begin
      check("step_ack_without_enable", {31'd0, step_ack}, 32'd0);
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle index of RUN entry.
  task automatic go(input int p, input int c, output int r);
    int k;
    k = cyc;
    period = PW'(p);
    cycles = CW'(c);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r = k + 2;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p, s;
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    period = '0; cycles = '0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_en", {31'd0, gray_clk_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_step_ack", {31'd0, step_ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cycle_cnt", {24'd0, cycle_cnt}, 32'd0);
    check("rst_gray_rst", {31'd0, gray_rst}, 32'd1);
    rst = 1'b0;
    #1 check("idle_gray_rst", {31'd0, gray_rst}, 32'd0);
    @(negedge clk);

    // 1: period 0, one full cycle
    go(0, 1, r);
    check("t1_clr_gray_rst", {31'd0, gray_rst}, 32'd1);
    check("t1_clr_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) push_en(r + 1 + i, 1'b0, gtab[i]);
    wait_to(r + 16);
    check("t1_done_early", {31'd0, done}, 32'd0);
    wait_to(r + 17);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_cycle_cnt", {24'd0, cycle_cnt}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_gray_in", {28'd0, gray_in}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_sb_drained", sb.size(), 32'd0);

    // 2: period 2, two cycles; input changes mid-run must not matter
    go(2, 2, r);
    period = 8'd0;
    cycles = 8'd5;
    for (int i = 0; i < 32; i++) push_en(r + 3 + 3 * i, 1'b0, gtab[i % 16]);
    wait_to(r + 96);
    check("t2_done_early", {31'd0, done}, 32'd0);
    wait_to(r + 97);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_cycle_cnt", {24'd0, cycle_cnt}, 32'd2);
    check("t2_sb_drained", sb.size(), 32'd0);

    // 3: free run, pause, three steps to en_cnt=7, resume
    go(3, 0, r);
    for (int i = 0; i < 4; i++) push_en(r + 4 + 4 * i, 1'b0, gtab[i]);
    wait_to(r + 16);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_pause_busy", {31'd0, busy}, 32'd1);
    check("t3_pause_gray_in", {28'd0, gray_in}, {28'd0, gtab[4]});
    for (int j = 0; j < 3; j++) begin
      p = cyc;
      push_en(p + 1, 1'b1, gtab[4 + j]);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("t3_step_gray_in", {28'd0, gray_in}, 32'h4);
    s = cyc;
    push_en(s + 5, 1'b0, gtab[7]);
    push_en(s + 9, 1'b0, gtab[8]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(s + 9);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_resume_gray_in", {28'd0, gray_in}, 32'hD);
    check("t3_cycle_cnt", {24'd0, cycle_cnt}, 32'd0);
    check("t3_sb_drained", sb.size(), 32'd0);
    do_rst();

    // 4: pause at en_cnt=15 of the last cycle, step completes the run
    go(0, 1, r);
    for (int i = 0; i < 15; i++) push_en(r + 1 + i, 1'b0, gtab[i]);
    wait_to(r + 15);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_pause_gray_in", {28'd0, gray_in}, 32'h8);
    check("t4_pause_done", {31'd0, done}, 32'd0);
    p = cyc;
    push_en(p + 1, 1'b1, 4'h8);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_gray_in", {28'd0, gray_in}, 32'd0);
    check("t4_cycle_cnt", {24'd0, cycle_cnt}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_sb_drained", sb.size(), 32'd0);

    // 5: stuck gray_in sets sticky err; a new start clears it
    stuck = 1'b1;
    go(1, 1, r);
    for (int i = 0; i < 16; i++) push_en(r + 2 + 2 * i, 1'b0, 4'h0);
    wait_to(r + 2);
    check("t5_err_first_en", {31'd0, err}, 32'd0);
    wait_to(r + 4);
    check("t5_err_set", {31'd0, err}, 32'd1);
    wait_to(r + 33);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_err_sticky", {31'd0, err}, 32'd1);
    stuck = 1'b0;
    go(0, 1, r);
    check("t5_err_cleared", {31'd0, err}, 32'd0);
    for (int i = 0; i < 16; i++) push_en(r + 1 + i, 1'b0, gtab[i]);
    wait_to(r + 17);
    check("t5_rerun_done", {31'd0, done}, 32'd1);
    check("t5_rerun_err", {31'd0, err}, 32'd0);
    check("t5_sb_drained", sb.size(), 32'd0);

    // 6: reset mid-run, then start+stop together in RUN
    go(0, 0, r);
    for (int i = 0; i < 5; i++) push_en(r + 1 + i, 1'b0, gtab[i]);
    wait_to(r + 5);
    rst = 1'b1;
    #1 check("t6_gray_rst_comb", {31'd0, gray_rst}, 32'd1);
    @(negedge clk);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_clk_en", {31'd0, gray_clk_en}, 32'd0);
    check("t6_cycle_cnt", {24'd0, cycle_cnt}, 32'd0);
    check("t6_gray_rst", {31'd0, gray_rst}, 32'd1);
    rst = 1'b0;
    #1 check("t6_gray_rst_rel", {31'd0, gray_rst}, 32'd0);
    @(negedge clk);
    go(1, 0, r);
    push_en(r + 2, 1'b0, gtab[0]);
    wait_to(r + 2);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_pause_busy", {31'd0, busy}, 32'd1);
    check("t6_pause_gray_in", {28'd0, gray_in}, {28'd0, gtab[1]});
    p = cyc;
    push_en(p + 1, 1'b1, gtab[1]);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_step_gray_in", {28'd0, gray_in}, {28'd0, gtab[2]});
    check("t6_sb_drained", sb.size(), 32'd0);
    do_rst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
